// File: rtl/lcd_pkg.sv
// Shared types and HD44780 constants for the LCD write engine.
package lcd_pkg;

  typedef enum logic [2:0] {
    StPowerup  = 3'd0,
    StInitLoad = 3'd1,
    StIdle     = 3'd2,
    StSetup    = 3'd3,
    StPulse    = 3'd4,
    StHold     = 3'd5,
    StWait     = 3'd6
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME       = 8'h02;
  localparam logic [7:0] LCD_CMD_HOME_ALT   = 8'h03;
  localparam logic [7:0] LCD_CMD_ENTRY      = 8'h06;
  localparam logic [7:0] LCD_CMD_DISPLAY_ON = 8'h0C;
  localparam logic [7:0] LCD_CMD_FUNC_8B2L  = 8'h38;

  localparam int unsigned LCD_INIT_LEN = 5;

  localparam logic [0:LCD_INIT_LEN-1][7:0] LCD_INIT_SEQ = '{
    LCD_CMD_FUNC_8B2L,
    LCD_CMD_FUNC_8B2L,
    LCD_CMD_DISPLAY_ON,
    LCD_CMD_CLEAR,
    LCD_CMD_ENTRY
  };

  // Clear and home need the long execution wait; DB0 is a don't-care for home.
  function automatic logic lcd_is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == LCD_CMD_CLEAR) || (b == LCD_CMD_HOME) || (b == LCD_CMD_HOME_ALT));
  endfunction

  function automatic int unsigned lcd_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that parks at zero; done_o flags the zero count.
module lcd_delay_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             fpga_clk_i,
  input  logic             fpga_reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             done_o
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge fpga_clk_i) begin
    if (fpga_reset_i) begin
      r_count <= WIDTH'(RESET_VALUE);
    end else if (load_i) begin
      r_count <= value_i;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done_o = (r_count == '0);

endmodule

// File: rtl/lcd_write_engine.sv
// HD44780 8-bit write-only bus driver: timed power-up init, then one byte per
// valid/ready handshake with programmable setup, pulse, hold and exec delays.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = 4,
  parameter int unsigned PULSE_CYCLES   = 50,
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned EXEC_CYCLES    = 4000,
  parameter int unsigned CLEAR_CYCLES   = 160000,
  parameter int unsigned POWERUP_CYCLES = 1500000
) (
  input  logic       fpga_clk_i,
  input  logic       fpga_reset_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  output logic       init_done_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_enable_o
);

  localparam int unsigned MaxCycles = lcd_max(lcd_max(lcd_max(SETUP_CYCLES, PULSE_CYCLES),
                                                      lcd_max(HOLD_CYCLES, EXEC_CYCLES)),
                                              lcd_max(CLEAR_CYCLES, POWERUP_CYCLES));
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;

  lcd_state_e      r_state;
  lcd_state_e      w_state_next;
  logic [2:0]      r_init_idx;
  logic            r_init_done;
  logic            r_rs;
  logic [7:0]      r_data;
  logic            r_enable;
  logic            w_done;
  logic            w_load;
  logic [CntW-1:0] w_load_value;
  logic            w_accept;
  logic            w_init_last;
  logic            w_init_finish;

  assign ready_o       = (r_state == StIdle) && r_init_done;
  assign w_accept      = valid_i && ready_o;
  assign w_init_last   = (r_init_idx == 3'(LCD_INIT_LEN));
  assign w_init_finish = (r_state == StWait) && w_done && !r_init_done && w_init_last;

  // Each timed state loads N-1 on entry and leaves when the count hits zero.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_value = '0;
    unique case (r_state)
      StPowerup: begin
        if (w_done) w_state_next = StInitLoad;
      end
      StInitLoad: begin
        w_state_next = StSetup;
        w_load       = 1'b1;
        w_load_value = CntW'(SETUP_CYCLES - 1);
      end
      StIdle: begin
        if (w_accept) begin
          w_state_next = StSetup;
          w_load       = 1'b1;
          w_load_value = CntW'(SETUP_CYCLES - 1);
        end
      end
      StSetup: begin
        if (w_done) begin
          w_state_next = StPulse;
          w_load       = 1'b1;
          w_load_value = CntW'(PULSE_CYCLES - 1);
        end
      end
      StPulse: begin
        if (w_done) begin
          w_state_next = StHold;
          w_load       = 1'b1;
          w_load_value = CntW'(HOLD_CYCLES - 1);
        end
      end
      StHold: begin
        if (w_done) begin
          w_state_next = StWait;
          w_load       = 1'b1;
          w_load_value = lcd_is_long_cmd(r_rs, r_data) ? CntW'(CLEAR_CYCLES - 1)
                                                       : CntW'(EXEC_CYCLES - 1);
        end
      end
      StWait: begin
        if (w_done) w_state_next = (r_init_done || w_init_last) ? StIdle : StInitLoad;
      end
      default: w_state_next = StPowerup;
    endcase
  end

  always_ff @(posedge fpga_clk_i) begin
    if (fpga_reset_i) begin
      r_state     <= StPowerup;
      r_init_idx  <= 3'd0;
      r_init_done <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_enable    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      // Registered decode of the next state keeps E free of input-driven glitches.
      r_enable <= (w_state_next == StPulse);
      if (r_state == StInitLoad) begin
        r_rs       <= 1'b0;
        r_data     <= LCD_INIT_SEQ[r_init_idx];
        r_init_idx <= r_init_idx + 3'd1;
      end
      if (w_accept) begin
        r_rs   <= rs_i;
        r_data <= data_i;
      end
      if (w_init_finish) r_init_done <= 1'b1;
    end
  end

  lcd_delay_counter #(
    .WIDTH       (CntW),
    .RESET_VALUE (POWERUP_CYCLES)
  ) u_delay_counter (
    .fpga_clk_i   (fpga_clk_i),
    .fpga_reset_i (fpga_reset_i),
    .load_i       (w_load),
    .value_i      (w_load_value),
    .done_o       (w_done)
  );

  assign init_done_o  = r_init_done;
  assign lcd_data_o   = r_data;
  assign lcd_rs_o     = r_rs;
  assign lcd_enable_o = r_enable;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Randomized self-checking bench for lcd_write_engine against a timing/byte-order model.
module tb_lcd_write_engine;

  localparam int S   = 2;
  localparam int P   = 3;
  localparam int H   = 1;
  localparam int EX  = 5;
  localparam int CLR = 20;
  localparam int PWR = 10;
  localparam int InitTime = PWR + 4 * (S + P + H + 1 + EX) + (S + P + H + 1 + CLR);

  logic       fpga_clk_i;
  logic       fpga_reset_i;
  logic       valid_i;
  logic       ready_o;
  logic       rs_i;
  logic [7:0] data_i;
  logic       init_done_o;
  logic [7:0] lcd_data_o;
  logic       lcd_rs_o;
  logic       lcd_enable_o;

  lcd_write_engine #(
    .SETUP_CYCLES   (S),
    .PULSE_CYCLES   (P),
    .HOLD_CYCLES    (H),
    .EXEC_CYCLES    (EX),
    .CLEAR_CYCLES   (CLR),
    .POWERUP_CYCLES (PWR)
  ) dut (
    .fpga_clk_i   (fpga_clk_i),
    .fpga_reset_i (fpga_reset_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .rs_i         (rs_i),
    .data_i       (data_i),
    .init_done_o  (init_done_o),
    .lcd_data_o   (lcd_data_o),
    .lcd_rs_o     (lcd_rs_o),
    .lcd_enable_o (lcd_enable_o)
  );

  initial fpga_clk_i = 1'b0;
  always #5 fpga_clk_i = ~fpga_clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int ready_early = 0;
  int e_len = 0;
  bit e_prev = 1'b0;
  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] init_bytes [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Bus monitor: every E rise is one written byte; every E pulse must be P cycles wide.
  always @(negedge fpga_clk_i) begin
    if (fpga_reset_i) begin
      e_len  = 0;
      e_prev = 1'b0;
    end else begin
      if (lcd_enable_o && !e_prev) begin
        obs_q.push_back({lcd_rs_o, lcd_data_o});
        e_len = 1;
      end else if (lcd_enable_o) begin
        e_len++;
      end else if (e_prev) begin
        check_eq("e_width", e_len, P);
      end
      e_prev = lcd_enable_o;
    end
    if (ready_o && !init_done_o) ready_early++;
  end

  function automatic bit is_long(input logic rs, input logic [7:0] d);
    return (rs == 1'b0) && (d == 8'h01 || d == 8'h02 || d == 8'h03);
  endfunction

  task automatic push_init();
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, init_bytes[i]});
  endtask

  task automatic compare_queues(input string tag);
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq(tag, int'(obs_q[i]), int'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done_o && n < 500) begin
      @(negedge fpga_clk_i);
      n++;
    end
  endtask

  // Called at a negedge; performs one handshake and checks the full bus timing.
  task automatic send_byte(input logic rs, input logic [7:0] d, output int waited);
    int lat, e_first, e_cnt, exp_lat;
    bit db_bad;
    valid_i = 1'b1;
    rs_i    = rs;
    data_i  = d;
    waited  = 0;
    while (!ready_o && waited < 200) begin
      @(negedge fpga_clk_i);
      waited++;
    end
    if (!ready_o) begin
      check_eq("send_ready_timeout", 0, 1);
      valid_i = 1'b0;
      return;
    end
    exp_q.push_back({rs, d});
    lat = 0; e_first = 0; e_cnt = 0; db_bad = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge fpga_clk_i);
      valid_i = 1'b0;
      data_i  = 8'($urandom);
      rs_i    = 1'($urandom);
      if ({lcd_rs_o, lcd_data_o} != {rs, d}) db_bad = 1'b1;
      if (ready_o) begin
        lat = k;
        break;
      end
      if (lcd_enable_o) begin
        if (e_first == 0) e_first = k;
        e_cnt++;
      end
    end
    exp_lat = S + P + H + (is_long(rs, d) ? CLR : EX) + 1;
    check_eq("ready_latency", lat, exp_lat);
    check_eq("e_first_cycle", e_first, S + 1);
    check_eq("e_high_cycles", e_cnt, P);
    check_eq("db_stable", int'(db_bad), 0);
  endtask

  initial begin
    int n, w, k, accepted, db_jump;
    bit acc_prev;
    logic [8:0] db_prev, cur;
    logic r;
    logic [7:0] d;

    fpga_reset_i = 1'b1;
    valid_i = 1'b0;
    rs_i    = 1'b0;
    data_i  = 8'h00;
    repeat (3) @(posedge fpga_clk_i);
    @(negedge fpga_clk_i);
    check_eq("rst_enable", lcd_enable_o, 0);
    check_eq("rst_rs", lcd_rs_o, 0);
    check_eq("rst_data", lcd_data_o, 0);
    check_eq("rst_ready", ready_o, 0);
    check_eq("rst_init_done", init_done_o, 0);

    // Early valid: byte is pending throughout init.
    valid_i = 1'b1;
    rs_i    = 1'b1;
    data_i  = 8'h55;
    push_init();
    fpga_reset_i = 1'b0;
    wait_init(n);
    check_eq("init_time_in_window", int'(n >= InitTime - 1 && n <= InitTime + 1), 1);
    check_eq("ready_at_init_done", ready_o, 1);
    compare_queues("init_bytes");
    send_byte(1'b1, 8'h55, w);
    check_eq("early_valid_wait", w, 0);

    send_byte(1'b1, 8'h41, w);
    send_byte(1'b0, 8'h01, w);
    send_byte(1'b0, 8'h80, w);
    for (int i = 0; i < 10; i++) begin
      r = 1'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        r = 1'b0;
        d = 8'($urandom_range(1, 3));
      end
      send_byte(r, d, w);
    end
    compare_queues("writes");

    // Busy-state inputs: valid held high, data churning every cycle.
    valid_i  = 1'b1;
    accepted = 0;
    k        = 0;
    db_jump  = 0;
    acc_prev = 1'b0;
    db_prev  = {lcd_rs_o, lcd_data_o};
    while (accepted < 3 && k < 400) begin
      rs_i     = 1'($urandom);
      data_i   = 8'($urandom);
      acc_prev = ready_o;
      if (ready_o) begin
        exp_q.push_back({rs_i, data_i});
        accepted++;
      end
      @(negedge fpga_clk_i);
      k++;
      cur = {lcd_rs_o, lcd_data_o};
      if (cur != db_prev && !acc_prev) db_jump++;
      db_prev = cur;
    end
    valid_i = 1'b0;
    while (!ready_o && k < 400) begin
      @(negedge fpga_clk_i);
      k++;
      cur = {lcd_rs_o, lcd_data_o};
      if (cur != db_prev) db_jump++;
      db_prev = cur;
    end
    check_eq("busy_accepted", accepted, 3);
    check_eq("busy_db_jumps", db_jump, 0);
    check_eq("busy_ready_back", ready_o, 1);
    compare_queues("busy");

    // Reset in the middle of an E pulse.
    valid_i = 1'b1;
    rs_i    = 1'b1;
    data_i  = 8'h33;
    n = 0;
    while (!ready_o && n < 100) begin
      @(negedge fpga_clk_i);
      n++;
    end
    @(negedge fpga_clk_i);
    valid_i = 1'b0;
    n = 0;
    while (!lcd_enable_o && n < 100) begin
      @(negedge fpga_clk_i);
      n++;
    end
    check_eq("mid_pulse_reached", lcd_enable_o, 1);
    fpga_reset_i = 1'b1;
    @(negedge fpga_clk_i);
    check_eq("mid_rst_enable", lcd_enable_o, 0);
    check_eq("mid_rst_init_done", init_done_o, 0);
    check_eq("mid_rst_ready", ready_o, 0);
    check_eq("mid_rst_data", lcd_data_o, 0);
    @(negedge fpga_clk_i);
    obs_q.delete();
    exp_q.delete();
    push_init();
    fpga_reset_i = 1'b0;
    wait_init(n);
    check_eq("replay_time_in_window", int'(n >= InitTime - 1 && n <= InitTime + 1), 1);
    compare_queues("replay");

    check_eq("ready_before_init", ready_early, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
